// File: rtl/controlador_edicion_rtc_pkg.sv
// -----------------------------------------------------------------------------
// controlador_edicion_rtc_pkg
// Shared definitions for the RTC edit controller:
//   - group encodings (hora / fecha / crono)
//   - edit FSM state encodings
//   - per-field packed-BCD limits and small helpers to look them up
//   - field-flag one-hot helper (bit order hh,mh,sh,df,mf,af,hc,mc,sc = 0..8)
// -----------------------------------------------------------------------------
package controlador_edicion_rtc_pkg;

    typedef enum logic [1:0] {
        GRP_HORA  = 2'd0,
        GRP_FECHA = 2'd1,
        GRP_CRONO = 2'd2
    } grupo_e;

    typedef enum logic [1:0] {
        EST_IDLE   = 2'd0,
        EST_EDIT   = 2'd1,
        EST_COMMIT = 2'd2
    } estado_e;

    localparam logic [7:0] HORA_MIN   = 8'h00;
    localparam logic [7:0] HORA_MAX   = 8'h23;
    localparam logic [7:0] MINSEG_MIN = 8'h00;
    localparam logic [7:0] MINSEG_MAX = 8'h59;
    localparam logic [7:0] DIA_MIN    = 8'h01;
    localparam logic [7:0] DIA_MAX    = 8'h31;
    localparam logic [7:0] MES_MIN    = 8'h01;
    localparam logic [7:0] MES_MAX    = 8'h12;
    localparam logic [7:0] ANO_MIN    = 8'h00;
    localparam logic [7:0] ANO_MAX    = 8'h99;

    // Lower limit of field c (0..2) of group g.
    function automatic logic [7:0] campo_min(input logic [1:0] g, input logic [1:0] c);
        logic [7:0] r;
        case (g)
            GRP_FECHA: begin
                case (c)
                    2'd0:    r = DIA_MIN;
                    2'd1:    r = MES_MIN;
                    default: r = ANO_MIN;
                endcase
            end
            default: begin
                case (c)
                    2'd0:    r = HORA_MIN;
                    default: r = MINSEG_MIN;
                endcase
            end
        endcase
        return r;
    endfunction

    // Upper limit of field c (0..2) of group g.
    function automatic logic [7:0] campo_max(input logic [1:0] g, input logic [1:0] c);
        logic [7:0] r;
        case (g)
            GRP_FECHA: begin
                case (c)
                    2'd0:    r = DIA_MAX;
                    2'd1:    r = MES_MAX;
                    default: r = ANO_MAX;
                endcase
            end
            default: begin
                case (c)
                    2'd0:    r = HORA_MAX;
                    default: r = MINSEG_MAX;
                endcase
            end
        endcase
        return r;
    endfunction

    // Loaded value: anything that is not a legal BCD value inside the field
    // range is replaced by the field minimum so the editor never starts from
    // a value the increment/decrement logic cannot step from.
    function automatic logic [7:0] bcd_cargar(input logic [7:0] v,
                                              input logic [7:0] mn,
                                              input logic [7:0] mx);
        logic [7:0] r;
        if ((v[7:4] > 4'd9) || (v[3:0] > 4'd9) || (v < mn) || (v > mx)) begin
            r = mn;
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [1:0] grupo_siguiente(input logic [1:0] g);
        logic [1:0] r;
        case (g)
            GRP_HORA:  r = GRP_FECHA;
            GRP_FECHA: r = GRP_CRONO;
            default:   r = GRP_HORA;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] cursor_siguiente(input logic [1:0] c);
        logic [1:0] r;
        case (c)
            2'd0:    r = 2'd1;
            2'd1:    r = 2'd2;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // One-hot field flag for (group, cursor).
    function automatic logic [8:0] bandera_onehot(input logic [1:0] g, input logic [1:0] c);
        logic [8:0] r;
        r = 9'd0;
        case ({g, c})
            4'b00_00: r[0] = 1'b1;
            4'b00_01: r[1] = 1'b1;
            4'b00_10: r[2] = 1'b1;
            4'b01_00: r[3] = 1'b1;
            4'b01_01: r[4] = 1'b1;
            4'b01_10: r[5] = 1'b1;
            4'b10_00: r[6] = 1'b1;
            4'b10_01: r[7] = 1'b1;
            4'b10_10: r[8] = 1'b1;
            default:  r = 9'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/controlador_edicion_rtc_bcd_ajuste.sv
// -----------------------------------------------------------------------------
// bcd_ajuste
// Combinational increment/decrement of one packed-BCD byte with wrap between
// lim_min and lim_max. inc and dec together (or neither) pass the value through.
// Ports:
//   valor      in  8  current BCD value (assumed legal, inside the limits)
//   lim_min    in  8  field minimum (BCD)
//   lim_max    in  8  field maximum (BCD)
//   inc, dec   in  1  step requests
//   resultado  out 8  adjusted BCD value
// -----------------------------------------------------------------------------
module bcd_ajuste (
    input  logic [7:0] valor,
    input  logic [7:0] lim_min,
    input  logic [7:0] lim_max,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] resultado
);

    // BCD step with decimal carry/borrow between the nibbles and range wrap.
    always_comb begin
        resultado = valor;
        if (inc && !dec) begin
            if (valor >= lim_max) begin
                resultado = lim_min;
            end else if (valor[3:0] >= 4'd9) begin
                resultado = {valor[7:4] + 4'd1, 4'd0};
            end else begin
                resultado = {valor[7:4], valor[3:0] + 4'd1};
            end
        end else if (dec && !inc) begin
            if (valor <= lim_min) begin
                resultado = lim_max;
            end else if (valor[3:0] == 4'd0) begin
                resultado = {valor[7:4] - 4'd1, 4'd9};
            end else begin
                resultado = {valor[7:4], valor[3:0] - 4'd1};
            end
        end else begin
            resultado = valor;
        end
    end

endmodule

// File: rtl/controlador_edicion_rtc.sv
// -----------------------------------------------------------------------------
// controlador_edicion_rtc
// Edit sequencer for the RTC time / date / chronometer overlay fields.
// IDLE: btn_mode cycles the group, btn_edit captures the group into the edit
// buffer. EDIT: btn_next moves the cursor, btn_up/btn_down step the field,
// btn_edit commits (one-cycle wr_strobe), inactivity abandons the edit.
// Optional build macro CTRL_EDIT_BLINK_EN: blinks the active field flag.
// Ports:
//   clk, reset (async, active low)
//   btn_mode, btn_edit, btn_next, btn_up, btn_down  single-cycle pulses
//   hora..c_seg   in  8   current packed-BCD values
//   val0..val2    out 8   edit buffer for the selected group
//   grp           out 2   0 hora, 1 fecha, 2 crono
//   editing       out 1   high in EDIT
//   bandera_*     out 1   field-under-cursor flags (registered)
//   wr_strobe     out 1   one-cycle commit pulse
// -----------------------------------------------------------------------------
module controlador_edicion_rtc
    import controlador_edicion_rtc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 32'd500_000_000,
    parameter int unsigned BLINK_DIV   = 32'd25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_edit,
    input  logic       btn_next,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [7:0] hora,
    input  logic [7:0] min,
    input  logic [7:0] seg,
    input  logic [7:0] dia,
    input  logic [7:0] mes,
    input  logic [7:0] ano,
    input  logic [7:0] c_hora,
    input  logic [7:0] c_min,
    input  logic [7:0] c_seg,
    output logic [7:0] val0,
    output logic [7:0] val1,
    output logic [7:0] val2,
    output logic [1:0] grp,
    output logic       editing,
    output logic       bandera_hh,
    output logic       bandera_mh,
    output logic       bandera_sh,
    output logic       bandera_df,
    output logic       bandera_mf,
    output logic       bandera_af,
    output logic       bandera_hc,
    output logic       bandera_mc,
    output logic       bandera_sc,
    output logic       wr_strobe
);

    localparam int unsigned TW = (TIMEOUT_CYC > 32'd1) ? $clog2(TIMEOUT_CYC) : 32'd1;
    localparam logic [TW-1:0] TOUT_ULT = TW'(TIMEOUT_CYC - 32'd1);

    estado_e     estado_r, estado_s;
    logic [1:0]  grp_r, grp_s;
    logic [1:0]  cursor_r, cursor_s;
    logic [7:0]  val_r [3];
    logic [7:0]  val_s [3];
    logic [7:0]  entrada_s [3];
    logic [TW-1:0] tout_r, tout_s;
    logic        btn_any_s;
    logic        tout_fin_s;
    logic [7:0]  aj_valor_s, aj_min_s, aj_max_s, aj_res_s;
    logic        aj_inc_s, aj_dec_s;
    logic        fase_act_s;
    logic        editing_s, editing_r;
    logic        wr_strobe_s, wr_strobe_r;
    logic [8:0]  bandera_s, bandera_r;

    assign btn_any_s  = btn_mode | btn_edit | btn_next | btn_up | btn_down;
    assign tout_fin_s = (tout_r == TOUT_ULT);

    // Current values of the selected group, field order 0/1/2.
    always_comb begin
        case (grp_r)
            GRP_FECHA: begin
                entrada_s[0] = dia;
                entrada_s[1] = mes;
                entrada_s[2] = ano;
            end
            GRP_CRONO: begin
                entrada_s[0] = c_hora;
                entrada_s[1] = c_min;
                entrada_s[2] = c_seg;
            end
            default: begin
                entrada_s[0] = hora;
                entrada_s[1] = min;
                entrada_s[2] = seg;
            end
        endcase
    end

    // Single shared adjuster fed with the field under the cursor.
    always_comb begin
        case (cursor_r)
            2'd1:    aj_valor_s = val_r[1];
            2'd2:    aj_valor_s = val_r[2];
            default: aj_valor_s = val_r[0];
        endcase
        aj_min_s = campo_min(grp_r, cursor_r);
        aj_max_s = campo_max(grp_r, cursor_r);
        aj_inc_s = btn_up & ~btn_down;
        aj_dec_s = btn_down & ~btn_up;
    end

    bcd_ajuste u_bcd_ajuste (
        .valor     (aj_valor_s),
        .lim_min   (aj_min_s),
        .lim_max   (aj_max_s),
        .inc       (aj_inc_s),
        .dec       (aj_dec_s),
        .resultado (aj_res_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_r <= EST_IDLE;
        end else begin
            estado_r <= estado_s;
        end
    end

    // FSM next state; btn_edit in EDIT wins over everything including timeout.
    always_comb begin
        case (estado_r)
            EST_IDLE: begin
                if (btn_edit) begin
                    estado_s = EST_EDIT;
                end else begin
                    estado_s = EST_IDLE;
                end
            end
            EST_EDIT: begin
                if (btn_edit) begin
                    estado_s = EST_COMMIT;
                end else if (!btn_any_s && tout_fin_s) begin
                    estado_s = EST_IDLE;
                end else begin
                    estado_s = EST_EDIT;
                end
            end
            EST_COMMIT: estado_s = EST_IDLE;
            default:    estado_s = EST_IDLE;
        endcase
    end

    // Next values of group, cursor, edit buffer and inactivity counter.
    always_comb begin
        grp_s    = grp_r;
        cursor_s = cursor_r;
        tout_s   = tout_r;
        for (int i = 0; i < 3; i++) begin
            val_s[i] = val_r[i];
        end
        case (estado_r)
            EST_IDLE: begin
                tout_s = '0;
                if (btn_edit) begin
                    cursor_s = 2'd0;
                    for (int i = 0; i < 3; i++) begin
                        val_s[i] = bcd_cargar(entrada_s[i],
                                              campo_min(grp_r, 2'(i)),
                                              campo_max(grp_r, 2'(i)));
                    end
                end else if (btn_mode) begin
                    grp_s = grupo_siguiente(grp_r);
                end else begin
                    grp_s = grp_r;
                end
            end
            EST_EDIT: begin
                if (btn_edit || btn_any_s || tout_fin_s) begin
                    tout_s = '0;
                end else begin
                    tout_s = tout_r + TW'(1'b1);
                end
                if (!btn_edit) begin
                    // Adjustment uses the old cursor; the cursor advances afterwards.
                    if (aj_inc_s || aj_dec_s) begin
                        case (cursor_r)
                            2'd1:    val_s[1] = aj_res_s;
                            2'd2:    val_s[2] = aj_res_s;
                            default: val_s[0] = aj_res_s;
                        endcase
                    end else begin
                        val_s[0] = val_r[0];
                    end
                    if (btn_next) begin
                        cursor_s = cursor_siguiente(cursor_r);
                    end else begin
                        cursor_s = cursor_r;
                    end
                end else begin
                    cursor_s = cursor_r;
                end
            end
            default: tout_s = '0;
        endcase
    end

    // Group, cursor, edit buffer and inactivity counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grp_r    <= 2'd0;
            cursor_r <= 2'd0;
            tout_r   <= '0;
            for (int i = 0; i < 3; i++) begin
                val_r[i] <= 8'h00;
            end
        end else begin
            grp_r    <= grp_s;
            cursor_r <= cursor_s;
            tout_r   <= tout_s;
            for (int i = 0; i < 3; i++) begin
                val_r[i] <= val_s[i];
            end
        end
    end

`ifdef CTRL_EDIT_BLINK_EN
    localparam int unsigned BW = (BLINK_DIV > 32'd1) ? $clog2(BLINK_DIV) : 32'd1;
    localparam logic [BW-1:0] BLINK_ULT = BW'(BLINK_DIV - 32'd1);

    logic [BW-1:0] blink_cnt_r, blink_cnt_s;
    logic          fase_r, fase_s;
    logic          reinicio_s;

    // Blink phase: restarts "on" when entering EDIT, moving the cursor or changing a value.
    always_comb begin
        reinicio_s = (estado_r != EST_EDIT) || (cursor_s != cursor_r) ||
                     (val_s[0] != val_r[0]) || (val_s[1] != val_r[1]) ||
                     (val_s[2] != val_r[2]);
        if (estado_s != EST_EDIT) begin
            blink_cnt_s = '0;
            fase_s      = 1'b1;
        end else if (reinicio_s) begin
            blink_cnt_s = '0;
            fase_s      = 1'b1;
        end else if (blink_cnt_r == BLINK_ULT) begin
            blink_cnt_s = '0;
            fase_s      = ~fase_r;
        end else begin
            blink_cnt_s = blink_cnt_r + BW'(1'b1);
            fase_s      = fase_r;
        end
    end

    // Blink counter and phase registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt_r <= '0;
            fase_r      <= 1'b1;
        end else begin
            blink_cnt_r <= blink_cnt_s;
            fase_r      <= fase_s;
        end
    end

    assign fase_act_s = fase_s;
`else
    assign fase_act_s = 1'b1;
`endif

    // Next registered outputs, decoded from the next state so they align with it.
    always_comb begin
        editing_s   = (estado_s == EST_EDIT);
        wr_strobe_s = (estado_s == EST_COMMIT);
        if (estado_s == EST_EDIT) begin
            bandera_s = bandera_onehot(grp_s, cursor_s) & {9{fase_act_s}};
        end else begin
            bandera_s = 9'd0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            editing_r   <= 1'b0;
            wr_strobe_r <= 1'b0;
            bandera_r   <= 9'd0;
        end else begin
            editing_r   <= editing_s;
            wr_strobe_r <= wr_strobe_s;
            bandera_r   <= bandera_s;
        end
    end

    assign val0      = val_r[0];
    assign val1      = val_r[1];
    assign val2      = val_r[2];
    assign grp       = grp_r;
    assign editing   = editing_r;
    assign wr_strobe = wr_strobe_r;
    assign {bandera_sc, bandera_mc, bandera_hc,
            bandera_af, bandera_mf, bandera_df,
            bandera_sh, bandera_mh, bandera_hh} = bandera_r;

endmodule

// File: tb/tb_controlador_edicion_rtc.sv
// -----------------------------------------------------------------------------
// tb_controlador_edicion_rtc
// Directed scenarios plus randomized button/value stimulus, checked every
// cycle against a decimal-arithmetic reference model of the edit controller.
// -----------------------------------------------------------------------------
module tb_controlador_edicion_rtc;

    localparam int unsigned T_CYC = 100;
    localparam int unsigned B_DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0, btn_edit = 1'b0, btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic [7:0] hora = 8'h00, min = 8'h00, seg = 8'h00, dia = 8'h01, mes = 8'h01, ano = 8'h00;
    logic [7:0] c_hora = 8'h00, c_min = 8'h00, c_seg = 8'h00;
    logic [7:0] val0, val1, val2;
    logic [1:0] grp;
    logic       editing, wr_strobe;
    logic       bandera_hh, bandera_mh, bandera_sh, bandera_df, bandera_mf, bandera_af;
    logic       bandera_hc, bandera_mc, bandera_sc;
    logic [8:0] flags_obs;

    assign flags_obs = {bandera_sc, bandera_mc, bandera_hc, bandera_af, bandera_mf,
                        bandera_df, bandera_sh, bandera_mh, bandera_hh};

    always #5 clk = ~clk;

    controlador_edicion_rtc #(.TIMEOUT_CYC(T_CYC), .BLINK_DIV(B_DIV)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_edit(btn_edit), .btn_next(btn_next),
        .btn_up(btn_up), .btn_down(btn_down),
        .hora(hora), .min(min), .seg(seg), .dia(dia), .mes(mes), .ano(ano),
        .c_hora(c_hora), .c_min(c_min), .c_seg(c_seg),
        .val0(val0), .val1(val1), .val2(val2), .grp(grp), .editing(editing),
        .bandera_hh(bandera_hh), .bandera_mh(bandera_mh), .bandera_sh(bandera_sh),
        .bandera_df(bandera_df), .bandera_mf(bandera_mf), .bandera_af(bandera_af),
        .bandera_hc(bandera_hc), .bandera_mc(bandera_mc), .bandera_sc(bandera_sc),
        .wr_strobe(wr_strobe)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: values kept as decimal integers; m_est 0=IDLE 1=EDIT 2=COMMIT.
    int m_vals [3];
    int m_grp, m_cur, m_est, m_quiet;

    task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_checks++;
        if (obs === esp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    function automatic logic [7:0] a_bcd(input int d);
        logic [7:0] r;
        r[7:4] = 4'(d / 10);
        r[3:0] = 4'(d % 10);
        return r;
    endfunction

    function automatic int lim_lo(input int g, input int f);
        if (g == 1 && f != 2) return 1;
        return 0;
    endfunction

    function automatic int lim_hi(input int g, input int f);
        if (g == 1) return (f == 0) ? 31 : ((f == 1) ? 12 : 99);
        return (f == 0) ? 23 : 59;
    endfunction

    function automatic logic [7:0] entrada(input int g, input int f);
        logic [7:0] t [9];
        t = '{hora, min, seg, dia, mes, ano, c_hora, c_min, c_seg};
        return t[g * 3 + f];
    endfunction

    function automatic int cargar(input int g, input int f);
        logic [7:0] v;
        int d;
        v = entrada(g, f);
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return lim_lo(g, f);
        d = int'(v[7:4]) * 10 + int'(v[3:0]);
        if (d < lim_lo(g, f) || d > lim_hi(g, f)) return lim_lo(g, f);
        return d;
    endfunction

    task automatic modelo_reset();
        for (int i = 0; i < 3; i++) m_vals[i] = 0;
        m_grp = 0; m_cur = 0; m_est = 0; m_quiet = 0;
    endtask

    task automatic modelo(input bit mo, input bit ed, input bit nx, input bit up, input bit dn);
        int lo, hi;
        case (m_est)
            0: begin
                if (ed) begin
                    for (int f = 0; f < 3; f++) m_vals[f] = cargar(m_grp, f);
                    m_cur = 0; m_est = 1; m_quiet = 0;
                end else if (mo) begin
                    m_grp = (m_grp + 1) % 3;
                end
            end
            1: begin
                if (ed) begin
                    m_est = 2;
                end else begin
                    lo = lim_lo(m_grp, m_cur);
                    hi = lim_hi(m_grp, m_cur);
                    if (up && !dn) m_vals[m_cur] = (m_vals[m_cur] == hi) ? lo : m_vals[m_cur] + 1;
                    if (dn && !up) m_vals[m_cur] = (m_vals[m_cur] == lo) ? hi : m_vals[m_cur] - 1;
                    if (nx) m_cur = (m_cur + 1) % 3;
                    if (mo || nx || up || dn) begin
                        m_quiet = 0;
                    end else begin
                        m_quiet++;
                        if (m_quiet == int'(T_CYC)) m_est = 0;
                    end
                end
            end
            default: m_est = 0;
        endcase
    endtask

    task automatic comparar_todo();
        logic [8:0] esp;
        logic [7:0] obs_v [3];
        obs_v = '{val0, val1, val2};
        esp = (m_est == 1) ? 9'(1 << (m_grp * 3 + m_cur)) : 9'd0;
        for (int i = 0; i < 3; i++) verificar($sformatf("val%0d", i), obs_v[i], a_bcd(m_vals[i]));
        verificar("grp", grp, m_grp);
        verificar("editing", editing, (m_est == 1));
        verificar("wr_strobe", wr_strobe, (m_est == 2));
`ifdef CTRL_EDIT_BLINK_EN
        verificar("banderas_subset", flags_obs & ~esp, 9'd0);
`else
        verificar("banderas", flags_obs, esp);
`endif
    endtask

    task automatic ciclo(input bit mo, input bit ed, input bit nx, input bit up, input bit dn);
        btn_mode = mo; btn_edit = ed; btn_next = nx; btn_up = up; btn_down = dn;
        @(posedge clk);
        modelo(mo, ed, nx, up, dn);
        #1;
        btn_mode = 1'b0; btn_edit = 1'b0; btn_next = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        comparar_todo();
    endtask

    function automatic logic [7:0] valor_aleatorio(input int lo, input int hi);
        logic [7:0] r;
        if ($urandom_range(0, 7) == 0) begin
            r[7:4] = 4'($urandom_range(10, 15));
            r[3:0] = 4'($urandom_range(0, 15));
        end else begin
            r = a_bcd(int'($urandom_range(lo, hi)));
        end
        return r;
    endfunction

    task automatic aleatorizar_entradas();
        hora = valor_aleatorio(0, 23);   min = valor_aleatorio(0, 59);   seg = valor_aleatorio(0, 59);
        dia = valor_aleatorio(1, 31);    mes = valor_aleatorio(1, 12);   ano = valor_aleatorio(0, 99);
        c_hora = valor_aleatorio(0, 23); c_min = valor_aleatorio(0, 59); c_seg = valor_aleatorio(0, 59);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        modelo_reset();
        repeat (2) @(posedge clk);
        #1;
        verificar("rst_val0", val0, 8'h00);
        verificar("rst_val1", val1, 8'h00);
        verificar("rst_grp", grp, 2'd0);
        verificar("rst_editing", editing, 1'b0);
        verificar("rst_wr", wr_strobe, 1'b0);
        verificar("rst_flags", flags_obs, 9'd0);
        reset = 1'b1;

        // Hour wrap 23 -> 00 and commit.
        hora = 8'h23; min = 8'h45; seg = 8'h12;
        ciclo(0, 1, 0, 0, 0);
        verificar("t1_edit_val0", val0, 8'h23);
        ciclo(0, 0, 0, 1, 0);
        verificar("t1_up_wrap", val0, 8'h00);
        ciclo(0, 1, 0, 0, 0);
        verificar("t1_strobe", wr_strobe, 1'b1);
        verificar("t1_strobe_grp", grp, 2'd0);
        verificar("t1_strobe_vals", {val0, val1, val2}, {8'h00, 8'h45, 8'h12});
        ciclo(0, 0, 0, 0, 0);
        verificar("t1_strobe_once", wr_strobe, 1'b0);

        // Date group: month down-wrap, day up-wrap.
        ciclo(1, 0, 0, 0, 0);
        dia = 8'h31; mes = 8'h01; ano = 8'h24;
        ciclo(0, 1, 0, 0, 0);
        ciclo(0, 0, 1, 0, 0);
        ciclo(0, 0, 0, 0, 1);
        verificar("t2_mes_wrap", val1, 8'h12);
        verificar("t2_flag_mf", flags_obs, 9'b0_0001_0000);
        ciclo(0, 0, 1, 0, 0);
        ciclo(0, 0, 1, 0, 0);
        ciclo(0, 0, 0, 1, 0);
        verificar("t2_dia_wrap", val0, 8'h01);
        ciclo(0, 1, 0, 0, 0);
        ciclo(0, 0, 0, 0, 0);

        // Back to hora; up+next together; up+down together.
        ciclo(1, 0, 0, 0, 0);
        ciclo(1, 0, 0, 0, 0);
        hora = 8'h10; min = 8'h30; seg = 8'h59;
        ciclo(0, 1, 0, 0, 0);
        ciclo(0, 0, 1, 0, 0);
        ciclo(0, 0, 1, 0, 0);
        ciclo(0, 0, 1, 1, 0);
        verificar("t3_seg_wrap", val2, 8'h00);
        verificar("t3_flag_hh", flags_obs, 9'b0_0000_0001);
        ciclo(0, 0, 0, 1, 1);
        verificar("t3_updown", val0, 8'h10);
        ciclo(0, 1, 0, 0, 0);
        ciclo(0, 0, 0, 0, 0);

        // Mode+edit together keeps grp; then inactivity timeout.
        ciclo(1, 1, 0, 0, 0);
        verificar("t4_grp_kept", grp, 2'd0);
        verificar("t4_editing", editing, 1'b1);
        for (int i = 0; i < int'(T_CYC) - 1; i++) ciclo(0, 0, 0, 0, 0);
        verificar("t4_before_tout", editing, 1'b1);
        ciclo(0, 0, 0, 0, 0);
        verificar("t4_tout", editing, 1'b0);
        verificar("t4_tout_nowr", wr_strobe, 1'b0);

`ifdef CTRL_EDIT_BLINK_EN
        ciclo(0, 1, 0, 0, 0);
        ciclo(0, 0, 0, 1, 0);
        verificar("blink_on", |flags_obs, 1'b1);
        repeat (B_DIV) ciclo(0, 0, 0, 0, 0);
        verificar("blink_off", |flags_obs, 1'b0);
        ciclo(0, 0, 0, 1, 0);
        verificar("blink_restart", |flags_obs, 1'b1);
        ciclo(0, 1, 0, 0, 0);
        ciclo(0, 0, 0, 0, 0);
`endif

        // Asynchronous reset in the middle of an edit.
        ciclo(1, 0, 0, 0, 0);
        ciclo(0, 1, 0, 0, 0);
        ciclo(0, 0, 0, 1, 0);
        #2;
        reset = 1'b0;
        #1;
        verificar("t5_rst_editing", editing, 1'b0);
        verificar("t5_rst_grp", grp, 2'd0);
        verificar("t5_rst_vals", {val0, val1, val2}, 24'h000000);
        verificar("t5_rst_flags", flags_obs, 9'd0);
        verificar("t5_rst_wr", wr_strobe, 1'b0);
        @(posedge clk);
        #1;
        verificar("t5_rst_hold_wr", wr_strobe, 1'b0);
        reset = 1'b1;
        modelo_reset();

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            aleatorizar_entradas();
            ciclo($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
